// File: rtl/wave_pkg.sv
// Shared types and defaults for the wave stream gate.
package wave_pkg;

   typedef enum logic [1:0] {
      StResync,
      StIdle,
      StPass,
      StDrop
   } wave_gate_st_t;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefCntW  = 16;

endpackage

// File: rtl/wave_gate_fifo.sv
// Synchronous per-channel FIFO holding {tlast, tdata}; exposes occupancy for frame-fit decisions.
module wave_gate_fifo
   import wave_pkg::*;
#(
   parameter int unsigned Depth = 16,
   parameter int unsigned Width = DefDataW + 1,
   localparam int unsigned AddrW = $clog2(Depth),
   localparam int unsigned CntW  = AddrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             wr_fire, rd_fire;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Depth));
   assign count_o = count_q;
   assign wr_fire = wr_en_i && !full_o;
   assign rd_fire = rd_en_i && !empty_o;

   // Empty FIFO presents zeros so tx data/tlast idle low, including out of reset.
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + AddrW'(1);
      if (wr_fire && !rd_fire) begin
         count_d = count_q + CntW'(1);
      end else if (!wr_fire && rd_fire) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/wave_stream_gate.sv
// N-channel frame-boundary gate from tready-less rx streams into back-pressured tx FIFOs.
// Statistics counters are compiled in only when WAVE_GATE_STATS_EN is defined.
module wave_stream_gate
   import wave_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = DefCntW
) (
   input  logic                       axis_clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic                       cnt_clr,
   input  logic [NUM_CH-1:0]          rx_tvalid,
   input  logic [NUM_CH*DATA_W-1:0]   rx_tdata,
   input  logic [NUM_CH-1:0]          rx_tlast,
   output logic [NUM_CH-1:0]          tx_tvalid,
   input  logic [NUM_CH-1:0]          tx_tready,
   output logic [NUM_CH*DATA_W-1:0]   tx_tdata,
   output logic [NUM_CH-1:0]          tx_tlast,
   output logic [NUM_CH*DATA_W/8-1:0] tx_tkeep,
   output logic [NUM_CH*CNT_W-1:0]    frm_cnt,
   output logic [NUM_CH*CNT_W-1:0]    drop_cnt
);

   localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

   assign tx_tkeep = '1;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      wave_gate_st_t       st_q, st_d;
      logic [FifoCntW-1:0] count;
      logic                full, empty;
      logic                free_ge1, free_ge2, free_eq1;
      logic                wr_en, wr_last, rd_en;
      logic                frm_inc, drop_inc;
      logic                rx_last;
      logic [DATA_W:0]     rd_data;

      assign rx_last  = rx_tlast[c];
      assign free_ge1 = !full;
      assign free_ge2 = (count < FifoCntW'(FIFO_DEPTH - 1));
      assign free_eq1 = (count == FifoCntW'(FIFO_DEPTH - 1));
      assign rd_en    = tx_tvalid[c] && tx_tready[c];

      always_comb begin
         st_d     = st_q;
         wr_en    = 1'b0;
         wr_last  = rx_last;
         frm_inc  = 1'b0;
         drop_inc = 1'b0;
         if (rx_tvalid[c]) begin
            case (st_q)
               StResync: begin
                  if (rx_last) st_d = StIdle;
               end
               StIdle: begin
                  if (!ch_en[c]) begin
                     if (!rx_last) st_d = StDrop;
                  end else if (rx_last && free_ge1) begin
                     wr_en   = 1'b1;
                     frm_inc = 1'b1;
                  end else if (!rx_last && free_ge2) begin
                     wr_en = 1'b1;
                     st_d  = StPass;
                  end else begin
                     drop_inc = 1'b1;
                     if (!rx_last) st_d = StDrop;
                  end
               end
               StPass: begin
                  if (rx_last) begin
                     st_d = StIdle;
                     if (free_ge1) begin
                        wr_en   = 1'b1;
                        frm_inc = 1'b1;
                     end
                  end else if (free_ge2) begin
                     wr_en = 1'b1;
                  end else begin
                     // Last slot: close the frame early so tx never sees an unterminated frame.
                     wr_en    = free_eq1;
                     wr_last  = 1'b1;
                     drop_inc = 1'b1;
                     st_d     = StDrop;
                  end
               end
               StDrop: begin
                  if (rx_last) st_d = StIdle;
               end
               default: st_d = StResync;
            endcase
         end
      end

      always_ff @(posedge axis_clk) begin
         if (!rst_n) st_q <= StResync;
         else        st_q <= st_d;
      end

      wave_gate_fifo #(
         .Depth (FIFO_DEPTH),
         .Width (DATA_W + 1)
      ) u_fifo (
         .clk_i     (axis_clk),
         .rst_ni    (rst_n),
         .wr_en_i   (wr_en),
         .wr_data_i ({wr_last, rx_tdata[c*DATA_W +: DATA_W]}),
         .rd_en_i   (rd_en),
         .rd_data_o (rd_data),
         .empty_o   (empty),
         .full_o    (full),
         .count_o   (count)
      );

      assign tx_tvalid[c]                 = !empty;
      assign tx_tdata[c*DATA_W +: DATA_W] = rd_data[DATA_W-1:0];
      assign tx_tlast[c]                  = rd_data[DATA_W];

`ifdef WAVE_GATE_STATS_EN
      logic [CNT_W-1:0] frm_cnt_q, drop_cnt_q;

      always_ff @(posedge axis_clk) begin
         if (!rst_n || cnt_clr) begin
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
         end else begin
            if (frm_inc) frm_cnt_q <= frm_cnt_q + CNT_W'(1);
            if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         end
      end

      assign frm_cnt[c*CNT_W +: CNT_W]  = frm_cnt_q;
      assign drop_cnt[c*CNT_W +: CNT_W] = drop_cnt_q;
`else
      logic unused_stats;
      assign unused_stats = ^{cnt_clr, frm_inc, drop_inc};

      assign frm_cnt[c*CNT_W +: CNT_W]  = '0;
      assign drop_cnt[c*CNT_W +: CNT_W] = '0;
`endif
   end

endmodule

// File: tb/tb_wave_stream_gate.sv
// Directed scoreboard bench for wave_stream_gate; counter expectations follow WAVE_GATE_STATS_EN.
module tb_wave_stream_gate;

   localparam int unsigned NumCh = 2;
   localparam int unsigned DataW = 32;
   localparam int unsigned Depth = 16;
   localparam int unsigned CntW  = 16;
`ifdef WAVE_GATE_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic                      axis_clk;
   logic                      rst_n;
   logic [NumCh-1:0]          ch_en;
   logic                      cnt_clr;
   logic [NumCh-1:0]          rx_tvalid;
   logic [NumCh*DataW-1:0]    rx_tdata;
   logic [NumCh-1:0]          rx_tlast;
   logic [NumCh-1:0]          tx_tvalid;
   logic [NumCh-1:0]          tx_tready;
   logic [NumCh*DataW-1:0]    tx_tdata;
   logic [NumCh-1:0]          tx_tlast;
   logic [NumCh*DataW/8-1:0]  tx_tkeep;
   logic [NumCh*CntW-1:0]     frm_cnt;
   logic [NumCh*CntW-1:0]     drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [DataW:0] exp_q0[$];
   logic [DataW:0] exp_q1[$];

   wave_stream_gate #(
      .NUM_CH     (NumCh),
      .DATA_W     (DataW),
      .FIFO_DEPTH (Depth),
      .CNT_W      (CntW)
   ) dut (
      .axis_clk  (axis_clk),
      .rst_n     (rst_n),
      .ch_en     (ch_en),
      .cnt_clr   (cnt_clr),
      .rx_tvalid (rx_tvalid),
      .rx_tdata  (rx_tdata),
      .rx_tlast  (rx_tlast),
      .tx_tvalid (tx_tvalid),
      .tx_tready (tx_tready),
      .tx_tdata  (tx_tdata),
      .tx_tlast  (tx_tlast),
      .tx_tkeep  (tx_tkeep),
      .frm_cnt   (frm_cnt),
      .drop_cnt  (drop_cnt)
   );

   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   // Drive one rx beat for a cycle; push the expected tx beat when it should be forwarded.
   task automatic beat(input int ch, input logic [DataW-1:0] data, input bit last,
                       input bit fwd, input bit fwd_last);
      rx_tvalid[ch]              = 1'b1;
      rx_tdata[ch*DataW +: DataW] = data;
      rx_tlast[ch]               = last;
      if (fwd) begin
         if (ch == 0) exp_q0.push_back({fwd_last, data});
         else         exp_q1.push_back({fwd_last, data});
      end
      tick();
      rx_tvalid[ch] = 1'b0;
      rx_tlast[ch]  = 1'b0;
   endtask

   function automatic logic [63:0] cnt(input logic [NumCh*CntW-1:0] v, input int ch);
      return 64'(v[ch*CntW +: CntW]);
   endfunction

   function automatic logic [63:0] sx(input int unsigned v);
      return StatsEn ? 64'(v) : 64'(0);
   endfunction

   always @(negedge axis_clk) begin
      if (tx_tvalid[0] && tx_tready[0]) begin
         check("ch0 beat expected", 64'(exp_q0.size() != 0), 64'(1));
         if (exp_q0.size() != 0)
            check("ch0 tx beat", 64'({tx_tlast[0], tx_tdata[0 +: DataW]}),
                  64'(exp_q0.pop_front()));
      end
      if (tx_tvalid[1] && tx_tready[1]) begin
         check("ch1 beat expected", 64'(exp_q1.size() != 0), 64'(1));
         if (exp_q1.size() != 0)
            check("ch1 tx beat", 64'({tx_tlast[1], tx_tdata[DataW +: DataW]}),
                  64'(exp_q1.pop_front()));
      end
   end

   initial begin
      rst_n     = 1'b0;
      ch_en     = 2'b11;
      cnt_clr   = 1'b0;
      rx_tvalid = '0;
      rx_tdata  = '0;
      rx_tlast  = '0;
      tx_tready = 2'b11;
      tick();
      tick();

      // Reset state
      check("reset tx_tvalid", 64'(tx_tvalid), 64'(0));
      check("reset tx_tlast", 64'(tx_tlast), 64'(0));
      check("reset tx_tdata", 64'(tx_tdata), 64'(0));
      check("reset tx_tkeep", 64'(tx_tkeep), 64'(8'hFF));
      check("reset frm_cnt", 64'(frm_cnt), 64'(0));
      check("reset drop_cnt", 64'(drop_cnt), 64'(0));
      rst_n = 1'b1;
      tick();

      // Enable and pass-through: clear RESYNC on both channels, then frames on ch0
      beat(0, 32'hDEAD, 1'b1, 1'b0, 1'b0);
      beat(1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
      check("resync not forwarded", 64'(tx_tvalid), 64'(0));
      beat(0, 32'hA0, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         beat(0, DataW'(i), i == 8, 1'b1, i == 8);
         if (i == 1) begin
            check("latency tx_tvalid", 64'(tx_tvalid[0]), 64'(1));
            check("latency tx_tdata", 64'(tx_tdata[0 +: DataW]), 64'(1));
         end
      end
      tick();
      check("frm_cnt ch0 after pass", cnt(frm_cnt, 0), sx(2));
      check("drop_cnt ch0 after pass", cnt(drop_cnt, 0), sx(0));

      // Disabled at frame start, enabled mid-frame: whole frame discarded, uncounted
      ch_en[1] = 1'b0;
      beat(1, 32'h11, 1'b0, 1'b0, 1'b0);
      ch_en[1] = 1'b1;
      for (int i = 2; i <= 4; i++) beat(1, DataW'(32'h10 + i), i == 4, 1'b0, 1'b0);
      tick();
      check("disabled frame not forwarded", 64'(tx_tvalid[1]), 64'(0));
      check("drop_cnt ch1 disabled", cnt(drop_cnt, 1), sx(0));
      for (int i = 1; i <= 3; i++) beat(1, DataW'(32'h20 + i), i == 3, 1'b1, i == 3);
      tick();
      check("frm_cnt ch1 after enable", cnt(frm_cnt, 1), sx(1));

      // Truncation: 20-beat frame into a stalled 16-deep FIFO
      tx_tready[0] = 1'b0;
      for (int i = 1; i <= 20; i++) beat(0, DataW'(32'h100 + i), i == 20, i <= 16, i == 16);
      tick();
      check("drop_cnt ch0 truncation", cnt(drop_cnt, 0), sx(1));
      check("frm_cnt ch0 truncation", cnt(frm_cnt, 0), sx(2));
      check("stall tx_tvalid", 64'(tx_tvalid[0]), 64'(1));
      tick();
      tick();
      check("stall holds tdata", 64'(tx_tdata[0 +: DataW]), 64'(32'h101));
      check("stall holds tlast", 64'(tx_tlast[0]), 64'(0));

      // Full at start: leave free==1, then a non-tlast frame start is dropped
      tx_tready[0] = 1'b1;
      tick();
      tx_tready[0] = 1'b0;
      check("head after single pop", 64'(tx_tdata[0 +: DataW]), 64'(32'h102));
      beat(0, 32'h200, 1'b0, 1'b0, 1'b0);
      beat(0, 32'h201, 1'b0, 1'b0, 1'b0);
      beat(0, 32'h202, 1'b1, 1'b0, 1'b0);
      check("drop_cnt ch0 full at start", cnt(drop_cnt, 0), sx(2));
      beat(0, 32'h5A, 1'b1, 1'b1, 1'b1);
      check("frm_cnt ch0 single beat", cnt(frm_cnt, 0), sx(3));

`ifdef WAVE_GATE_STATS_EN
      // FIFO now full: every single-beat frame is a drop; push drop_cnt to saturation
      rx_tvalid[0] = 1'b1;
      rx_tlast[0]  = 1'b1;
      repeat (65533) tick();
      check("drop_cnt reaches max", cnt(drop_cnt, 0), 64'(16'hFFFF));
      tick();
      check("drop_cnt saturates", cnt(drop_cnt, 0), 64'(16'hFFFF));
      rx_tvalid[0] = 1'b0;
      rx_tlast[0]  = 1'b0;
`endif

      // Counter clear coincident with a frame end
      cnt_clr = 1'b1;
      beat(0, 32'h77, 1'b1, 1'b0, 1'b0);
      cnt_clr = 1'b0;
      check("cnt_clr drop_cnt", 64'(drop_cnt), 64'(0));
      check("cnt_clr frm_cnt", 64'(frm_cnt), 64'(0));

      tx_tready[0] = 1'b1;
      repeat (20) tick();
      check("ch0 drained", 64'(exp_q0.size()), 64'(0));

      // Reset for one cycle during beat 3 of 6
      beat(0, 32'h301, 1'b0, 1'b1, 1'b0);
      beat(0, 32'h302, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      beat(0, 32'h303, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      check("tx_tvalid after mid-frame reset", 64'(tx_tvalid), 64'(0));
      for (int i = 4; i <= 6; i++) beat(0, DataW'(32'h300 + i), i == 6, 1'b0, 1'b0);
      tick();
      check("rest of frame discarded", 64'(tx_tvalid[0]), 64'(0));
      for (int i = 1; i <= 4; i++) beat(0, DataW'(32'h400 + i), i == 4, 1'b1, i == 4);
      repeat (4) tick();
      check("frm_cnt ch0 after reset", cnt(frm_cnt, 0), sx(1));
      check("drop_cnt ch0 after reset", cnt(drop_cnt, 0), sx(0));

      check("ch0 scoreboard empty", 64'(exp_q0.size()), 64'(0));
      check("ch1 scoreboard empty", 64'(exp_q1.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
